// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the single-bus CPU control unit: opcodes, ALU operations,
// sequencer states, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Zero is reserved for "no operation" so an idle alu_op is distinguishable.
  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_SHR  = 5'd5;
  localparam logic [4:0] ALU_SHRA = 5'd6;
  localparam logic [4:0] ALU_SHL  = 5'd7;
  localparam logic [4:0] ALU_ROR  = 5'd8;
  localparam logic [4:0] ALU_ROL  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd10;
  localparam logic [4:0] ALU_DIV  = 5'd11;
  localparam logic [4:0] ALU_NEG  = 5'd12;
  localparam logic [4:0] ALU_NOT  = 5'd13;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_IMM, CLS_UNARY, CLS_LD, CLS_ST, CLS_BR,
    CLS_MFHI, CLS_MFLO, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILL
  } cls_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic ir_in;
    logic mdr_in;
    logic mdr_out;
    logic md_read;
    logic mem_write;
    logic y_in;
    logic z_in;
    logic z_low_out;
    logic z_high_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic con_in;
    logic hi_in;
    logic lo_in;
    logic hi_out;
    logic lo_out;
  } strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode -> instruction class and ALU operation. mul/div are decoded only when
// MUL_DIV_EN is defined; otherwise they fall into the illegal class.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic [OPW-1:0]  op,
  output cls_e            cls,
  output logic [ALUW-1:0] alu_op
);

  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALUW'(ALU_NONE);
    case (op)
      OP_ADD:  begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_ADD);  end
      OP_SUB:  begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_SUB);  end
      OP_AND:  begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_AND);  end
      OP_OR:   begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_OR);   end
      OP_SHR:  begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_SHR);  end
      OP_SHRA: begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_SHRA); end
      OP_SHL:  begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_SHL);  end
      OP_ROR:  begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_ROR);  end
      OP_ROL:  begin cls = CLS_RTYPE; alu_op = ALUW'(ALU_ROL);  end
      OP_ADDI: begin cls = CLS_IMM;   alu_op = ALUW'(ALU_ADD);  end
      OP_ANDI: begin cls = CLS_IMM;   alu_op = ALUW'(ALU_AND);  end
      OP_ORI:  begin cls = CLS_IMM;   alu_op = ALUW'(ALU_OR);   end
      OP_NEG:  begin cls = CLS_UNARY; alu_op = ALUW'(ALU_NEG);  end
      OP_NOT:  begin cls = CLS_UNARY; alu_op = ALUW'(ALU_NOT);  end
      OP_LD:   cls = CLS_LD;
      OP_ST:   cls = CLS_ST;
      OP_BR:   cls = CLS_BR;
      OP_MFHI: cls = CLS_MFHI;
      OP_MFLO: cls = CLS_MFLO;
      OP_NOP:  cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
`ifdef MUL_DIV_EN
      OP_MUL:  begin cls = CLS_MULDIV; alu_op = ALUW'(ALU_MUL); end
      OP_DIV:  begin cls = CLS_MULDIV; alu_op = ALUW'(ALU_DIV); end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus CPU: fetch (T0-T2), decode and
// execute (T3-T7), IDLE and HALT. Define MUL_DIV_EN to enable mul/div sequencing.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  input  logic            con_ff,
  output logic            pc_out,
  output logic            mar_in,
  output logic            inc_pc,
  output logic            pc_in,
  output logic            ir_in,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            md_read,
  output logic            mem_write,
  output logic            y_in,
  output logic            z_in,
  output logic            z_low_out,
  output logic            z_high_out,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            r_in,
  output logic            r_out,
  output logic            ba_out,
  output logic            c_out,
  output logic            con_in,
  output logic            hi_in,
  output logic            lo_in,
  output logic            hi_out,
  output logic            lo_out,
  output logic [ALUW-1:0] alu_op,
  output logic            halted,
  output logic            illegal,
  output logic [3:0]      state_dbg
);

  // Memory handshake: mem_ready is looked at only in T1, ld T6 and st T7; the
  // state (and so every strobe) holds until mem_ready=1 is seen on a rising edge.

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q;
  logic [OPW-1:0]  dec_op;
  cls_e            cls;
  logic [ALUW-1:0] dec_alu;
  state_e          boundary;
  strobes_t        s;
  logic [ALUW-1:0] alu_sel;
  logic            ill_d;
  logic            hlt_d;
  logic            unused_ir;

  assign unused_ir = ^ir[31-OPW:0];

  // ir must be stable by T2: nop/halt skip execute straight from T2, and op_q
  // captures the opcode on the T2 exit edge so T3 onward depends only on registers.
  assign dec_op = (state_q == T2) ? ir[31:32-OPW] : op_q;

  ctrl_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
    .op     (dec_op),
    .cls    (cls),
    .alu_op (dec_alu)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T2) op_q <= ir[31:32-OPW];
    end
  end

  assign boundary = run ? T0 : IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (run) state_d = T0;
      T0:   state_d = T1;
      T1:   if (mem_ready) state_d = T2;
      T2: begin
        case (cls)
          CLS_NOP:  state_d = boundary;
          CLS_HALT: state_d = HALT;
          default:  state_d = T3;
        endcase
      end
      T3: begin
        case (cls)
          CLS_MFHI, CLS_MFLO, CLS_ILL, CLS_NOP, CLS_HALT: state_d = boundary;
          default: state_d = T4;
        endcase
      end
      T4: state_d = (cls == CLS_UNARY) ? boundary : T5;
      T5: state_d = (cls == CLS_RTYPE || cls == CLS_IMM) ? boundary : T6;
      T6: begin
        case (cls)
          CLS_LD:  if (mem_ready) state_d = T7;
          CLS_ST:  state_d = T7;
          default: state_d = boundary;
        endcase
      end
      T7: begin
        if (cls != CLS_ST || mem_ready) state_d = boundary;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s       = '0;
    alu_sel = ALUW'(ALU_NONE);
    ill_d   = 1'b0;
    hlt_d   = 1'b0;
    case (state_q)
      T0: begin
        s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1;
        alu_sel  = ALUW'(ALU_ADD);
      end
      T1: begin s.z_low_out = 1'b1; s.pc_in = 1'b1; s.md_read = 1'b1; s.mdr_in = 1'b1; end
      T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
      T3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
          CLS_UNARY: begin
            s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; alu_sel = dec_alu;
          end
          CLS_LD, CLS_ST: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
          CLS_BR:     begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
          CLS_MFHI:   begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CLS_MFLO:   begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CLS_MULDIV: begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
          CLS_ILL:    ill_d = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_RTYPE: begin
            s.grc = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; alu_sel = dec_alu;
          end
          CLS_IMM:   begin s.c_out = 1'b1; s.z_in = 1'b1; alu_sel = dec_alu; end
          CLS_UNARY: begin s.z_low_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CLS_LD, CLS_ST: begin
            s.c_out = 1'b1; s.z_in = 1'b1; alu_sel = ALUW'(ALU_ADD);
          end
          CLS_BR:    begin s.pc_out = 1'b1; s.y_in = 1'b1; end
          CLS_MULDIV: begin
            s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; alu_sel = dec_alu;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin s.z_low_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CLS_LD, CLS_ST:     begin s.z_low_out = 1'b1; s.mar_in = 1'b1; end
          CLS_BR: begin s.c_out = 1'b1; s.z_in = 1'b1; alu_sel = ALUW'(ALU_ADD); end
          CLS_MULDIV:         begin s.z_low_out = 1'b1; s.lo_in = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD: begin s.md_read = 1'b1; s.mdr_in = 1'b1; end
          CLS_ST: begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
          // con_ff was loaded back in T3 and is stable by now.
          CLS_BR: begin s.z_low_out = con_ff; s.pc_in = con_ff; end
          CLS_MULDIV: begin s.z_high_out = 1'b1; s.hi_in = 1'b1; end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CLS_LD: begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
          CLS_ST: s.mem_write = 1'b1;
          default: ;
        endcase
      end
      HALT: hlt_d = 1'b1;
      default: ;
    endcase
  end

  assign pc_out     = s.pc_out;
  assign mar_in     = s.mar_in;
  assign inc_pc     = s.inc_pc;
  assign pc_in      = s.pc_in;
  assign ir_in      = s.ir_in;
  assign mdr_in     = s.mdr_in;
  assign mdr_out    = s.mdr_out;
  assign md_read    = s.md_read;
  assign mem_write  = s.mem_write;
  assign y_in       = s.y_in;
  assign z_in       = s.z_in;
  assign z_low_out  = s.z_low_out;
  assign z_high_out = s.z_high_out;
  assign gra        = s.gra;
  assign grb        = s.grb;
  assign grc        = s.grc;
  assign r_in       = s.r_in;
  assign r_out      = s.r_out;
  assign ba_out     = s.ba_out;
  assign c_out      = s.c_out;
  assign con_in     = s.con_in;
  assign hi_in      = s.hi_in;
  assign lo_in      = s.lo_in;
  assign hi_out     = s.hi_out;
  assign lo_out     = s.lo_out;
  assign alu_op     = alu_sel;
  assign halted     = hlt_d;
  assign illegal    = ill_d;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a per-instruction micro-step table model feeds an
// expected queue that one negedge compare process checks every cycle.
`timescale 1ns/1ps
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int W = 32;
  localparam int PC_OUT = 0, MAR_IN = 1, INC_PC = 2, PC_IN = 3, IR_IN = 4, MDR_IN = 5;
  localparam int MDR_OUT = 6, MD_READ = 7, MEM_WRITE = 8, Y_IN = 9, Z_IN = 10;
  localparam int Z_LOW_OUT = 11, Z_HIGH_OUT = 12, GRA = 13, GRB = 14, GRC = 15;
  localparam int R_IN = 16, R_OUT = 17, BA_OUT = 18, C_OUT = 19, CON_IN = 20;
  localparam int HI_IN = 21, LO_IN = 22, HI_OUT = 23, LO_OUT = 24, HALTED = 30, ILLEGAL = 31;
  localparam int C_R = 0, C_IMM = 1, C_UN = 2, C_LD = 3, C_ST = 4, C_BR = 5;
  localparam int C_MFHI = 6, C_MFLO = 7, C_MD = 8, C_NOP = 9, C_HALT = 10, C_ILL = 11;

  logic clk, clr, run, mem_ready, con_ff;
  logic [31:0] ir;
  logic pc_out, mar_in, inc_pc, pc_in, ir_in, mdr_in, mdr_out, md_read, mem_write;
  logic y_in, z_in, z_low_out, z_high_out, gra, grb, grc, r_in, r_out, ba_out;
  logic c_out, con_in, hi_in, lo_in, hi_out, lo_out, halted, illegal;
  logic [4:0] alu_op;
  logic [3:0] state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_seq[$];
  logic         m_mr[$];
  logic [W-1:0] dut_v;
  logic [W-1:0] e_v;
  int checks = 0;
  int errors = 0;
  int n;

  control_sequencer #(.OPW(5), .ALUW(5)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready), .con_ff(con_ff),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in), .ir_in(ir_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .md_read(md_read), .mem_write(mem_write),
    .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out), .z_high_out(z_high_out),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .c_out(c_out), .con_in(con_in), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out),
    .lo_out(lo_out), .alu_op(alu_op), .halted(halted), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  always_comb begin
    dut_v = '0;
    dut_v[PC_OUT] = pc_out;   dut_v[MAR_IN] = mar_in;       dut_v[INC_PC] = inc_pc;
    dut_v[PC_IN] = pc_in;     dut_v[IR_IN] = ir_in;         dut_v[MDR_IN] = mdr_in;
    dut_v[MDR_OUT] = mdr_out; dut_v[MD_READ] = md_read;     dut_v[MEM_WRITE] = mem_write;
    dut_v[Y_IN] = y_in;       dut_v[Z_IN] = z_in;           dut_v[Z_LOW_OUT] = z_low_out;
    dut_v[Z_HIGH_OUT] = z_high_out; dut_v[GRA] = gra;       dut_v[GRB] = grb;
    dut_v[GRC] = grc;         dut_v[R_IN] = r_in;           dut_v[R_OUT] = r_out;
    dut_v[BA_OUT] = ba_out;   dut_v[C_OUT] = c_out;         dut_v[CON_IN] = con_in;
    dut_v[HI_IN] = hi_in;     dut_v[LO_IN] = lo_in;         dut_v[HI_OUT] = hi_out;
    dut_v[LO_OUT] = lo_out;
    if (z_in) dut_v[29:25] = alu_op;
    dut_v[HALTED] = halted;   dut_v[ILLEGAL] = illegal;
  end

  // scoreboard: one expected vector per clock cycle
  always @(negedge clk) begin
    if (clr && exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      checks++;
      if (dut_v !== e_v) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t state=%0d got=%h exp=%h", $time, state_dbg, dut_v, e_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  function automatic logic [W-1:0] b(input int i);
    logic [W-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] av(input logic [4:0] v);
    logic [W-1:0] r;
    r = '0;
    r[29:25] = v;
    return r;
  endfunction

  function automatic int cls_of(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return C_R;
      5'b01100, 5'b01101, 5'b01110: return C_IMM;
      5'b10001, 5'b10010: return C_UN;
      5'b00000: return C_LD;
      5'b00010: return C_ST;
      5'b10011: return C_BR;
      5'b11000: return C_MFHI;
      5'b11001: return C_MFLO;
      5'b11010: return C_NOP;
      5'b11011: return C_HALT;
`ifdef MUL_DIV_EN
      5'b01111, 5'b10000: return C_MD;
`endif
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input logic [4:0] op);
    case (op)
      5'b00011, 5'b01100: return ALU_ADD;
      5'b00100: return ALU_SUB;
      5'b00101, 5'b01101: return ALU_AND;
      5'b00110, 5'b01110: return ALU_OR;
      5'b00111: return ALU_ROR;
      5'b01000: return ALU_ROL;
      5'b01001: return ALU_SHR;
      5'b01010: return ALU_SHRA;
      5'b01011: return ALU_SHL;
      5'b01111: return ALU_MUL;
      5'b10000: return ALU_DIV;
      5'b10001: return ALU_NEG;
      5'b10010: return ALU_NOT;
      default:  return ALU_NONE;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic [W-1:0] v, input logic mr);
    m_seq.push_back(v);
    m_mr.push_back(mr);
  endtask

  // Build the cycle-by-cycle expectation for one instruction and drive it.
  // Entry and exit: just after the rising edge that entered T0 (or IDLE at exit).
  task automatic do_instr(input logic [31:0] instr, input logic con, input int w1,
                          input int w2, input logic run_after, output int len);
    logic [4:0] op;
    logic [W-1:0] alu_v, mem_v;
    int c;
    op = instr[31:27];
    c = cls_of(op);
    alu_v = av(alu_of(op));
    m_seq.delete();
    m_mr.delete();
    add(b(PC_OUT) | b(MAR_IN) | b(INC_PC) | b(Z_IN) | av(ALU_ADD), rb());
    for (int i = 0; i < w1; i++) add(b(Z_LOW_OUT) | b(PC_IN) | b(MD_READ) | b(MDR_IN), 1'b0);
    add(b(Z_LOW_OUT) | b(PC_IN) | b(MD_READ) | b(MDR_IN), 1'b1);
    add(b(MDR_OUT) | b(IR_IN), rb());
    case (c)
      C_R, C_IMM: begin
        add(b(GRB) | b(R_OUT) | b(Y_IN), rb());
        if (c == C_R) add(b(GRC) | b(R_OUT) | b(Z_IN) | alu_v, rb());
        else          add(b(C_OUT) | b(Z_IN) | alu_v, rb());
        add(b(Z_LOW_OUT) | b(GRA) | b(R_IN), rb());
      end
      C_UN: begin
        add(b(GRB) | b(R_OUT) | b(Z_IN) | alu_v, rb());
        add(b(Z_LOW_OUT) | b(GRA) | b(R_IN), rb());
      end
      C_LD, C_ST: begin
        add(b(GRB) | b(BA_OUT) | b(Y_IN), rb());
        add(b(C_OUT) | b(Z_IN) | av(ALU_ADD), rb());
        add(b(Z_LOW_OUT) | b(MAR_IN), rb());
        if (c == C_LD) begin
          mem_v = b(MD_READ) | b(MDR_IN);
          for (int i = 0; i < w2; i++) add(mem_v, 1'b0);
          add(mem_v, 1'b1);
          add(b(MDR_OUT) | b(GRA) | b(R_IN), rb());
        end else begin
          add(b(GRA) | b(R_OUT) | b(MDR_IN), rb());
          for (int i = 0; i < w2; i++) add(b(MEM_WRITE), 1'b0);
          add(b(MEM_WRITE), 1'b1);
        end
      end
      C_BR: begin
        add(b(GRA) | b(R_OUT) | b(CON_IN), rb());
        add(b(PC_OUT) | b(Y_IN), rb());
        add(b(C_OUT) | b(Z_IN) | av(ALU_ADD), rb());
        add(con ? (b(Z_LOW_OUT) | b(PC_IN)) : '0, rb());
      end
      C_MFHI: add(b(HI_OUT) | b(GRA) | b(R_IN), rb());
      C_MFLO: add(b(LO_OUT) | b(GRA) | b(R_IN), rb());
      C_MD: begin
        add(b(GRA) | b(R_OUT) | b(Y_IN), rb());
        add(b(GRB) | b(R_OUT) | b(Z_IN) | alu_v, rb());
        add(b(Z_LOW_OUT) | b(LO_IN), rb());
        add(b(Z_HIGH_OUT) | b(HI_IN), rb());
      end
      C_ILL: add(b(ILLEGAL), rb());
      default: ;
    endcase
    len = m_seq.size();
    ir = instr;
    con_ff = con;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(m_seq[i]);
      mem_ready = m_mr[i];
      run = (i == len - 1) ? run_after : rb();
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int cyc, input logic go);
    for (int i = 0; i < cyc; i++) begin
      exp_q.push_back('0);
      run = 1'b0;
      mem_ready = rb();
      @(posedge clk); #1;
    end
    if (go) begin
      exp_q.push_back('0);
      run = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic halt_cycles(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      exp_q.push_back(b(HALTED));
      run = rb();
      mem_ready = rb();
      @(posedge clk); #1;
    end
  endtask

  logic [4:0] op_tab[25];
  logic [4:0] rop;
  logic ra;

  initial begin
    op_tab = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
               5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110,
               5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11000, 5'b11001,
               5'b11010, 5'b11111, 5'b10100, 5'b00001};
    clr = 1'b0; run = 1'b0; ir = '0; mem_ready = 1'b0; con_ff = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", dut_v, 32'h0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    clr = 1'b1;
    idle(4, 1'b0);
    chk("idle_state_run0", 32'(state_dbg), 32'(IDLE));
    idle(1, 1'b1);

    // directed instructions
    do_instr(32'h18918000, 1'b0, 0, 0, 1'b1, n);
    chk("len_add", n, 6);
    do_instr(32'h00900010, 1'b0, 0, 3, 1'b1, n);
    chk("len_ld_wait3", n, 11);
    do_instr({5'b10011, 27'h0123456}, 1'b0, 0, 0, 1'b1, n);
    chk("len_br", n, 7);
    do_instr({5'b10011, 27'h0123456}, 1'b1, 0, 0, 1'b1, n);
    do_instr({5'b11111, 27'h0}, 1'b0, 0, 0, 1'b1, n);
    chk("len_illegal", n, 4);
    do_instr({5'b01111, 27'h0}, 1'b0, 0, 0, 1'b1, n);
`ifdef MUL_DIV_EN
    chk("len_mul", n, 7);
`else
    chk("len_mul", n, 4);
`endif
    do_instr({5'b11010, 27'h0}, 1'b0, 0, 0, 1'b1, n);
    chk("len_nop", n, 3);
    do_instr({5'b10001, 27'h0}, 1'b0, 0, 0, 1'b1, n);
    chk("len_neg", n, 5);
    do_instr({5'b11000, 27'h0}, 1'b0, 0, 0, 1'b1, n);
    chk("len_mfhi", n, 4);
    do_instr({5'b00010, 27'h0}, 1'b0, 2, 1, 1'b0, n);
    chk("len_st_waits", n, 11);
    idle(2, 1'b1);

    // randomized stream
    for (int k = 0; k < 60; k++) begin
      rop = op_tab[$urandom_range(0, 24)];
      ra = rb();
      do_instr({rop, 27'($urandom)}, rb(), $urandom_range(0, 3), $urandom_range(0, 3), ra, n);
      if (!ra) idle($urandom_range(0, 2), 1'b1);
    end

    // reset during the T1 memory wait
    exp_q.push_back(b(PC_OUT) | b(MAR_IN) | b(INC_PC) | b(Z_IN) | av(ALU_ADD));
    ir = 32'h00900010; mem_ready = 1'b0; run = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(b(Z_LOW_OUT) | b(PC_IN) | b(MD_READ) | b(MDR_IN));
    @(posedge clk); #1;
    chk("wait_state_t1", 32'(state_dbg), 32'(T1));
    clr = 1'b0;
    #1;
    chk("reset_mid_outputs", dut_v, 32'h0);
    chk("reset_mid_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1;
    clr = 1'b1;
    idle(1, 1'b1);

    // halt, then run toggling has no effect until clr
    do_instr({5'b11011, 27'h0}, 1'b0, 1, 0, 1'b1, n);
    chk("len_halt_fetch", n, 4);
    halt_cycles(6);
    chk("halted_state", 32'(state_dbg), 32'(HALT));
    clr = 1'b0;
    #1;
    chk("reset_from_halt", dut_v, 32'h0);
    @(posedge clk); #1;
    clr = 1'b1;
    idle(2, 1'b0);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
